// File: rtl/clock_mode_controller.sv
// rtl/clock_mode_controller.sv - alarm clock mode/time-keeping controller
//
// Purpose: keeps time of day (hour:min:sec), holds an alarm time, lets the
// user edit clock and alarm fields with five buttons and sounds the buzzer
// when a tick-driven minute rollover lands on the alarm time.
//
// Optional feature: define CLOCK_SNOOZE_EN to add snooze (btn_u in RING
// re-arms the alarm SNOOZE_MIN minutes later). Without it, any button in
// RING silences the alarm.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   tick_1hz      one-cycle pulse per second
//   btn_c/l/r/u/d debounced one-cycle button pulses (priority C>R>L>U>D)
//   disp_hour     displayed hour (0..23)
//   disp_min      displayed minute (0..59)
//   dp_blink_en   decimal point may blink (CLOCK, RING)
//   adj_led       one-hot field being edited {alm min, alm hour, min, hour}
//   adj_mode_led  high in any adjust state
//   buzzer        alarm sounding

module clock_mode_controller #(
    parameter int SEC_PER_MIN = 60,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_min,
    output logic       dp_blink_en,
    output logic [3:0] adj_led,
    output logic       adj_mode_led,
    output logic       buzzer
);

    localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

    if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze
        $error("SNOOZE_MIN must be in 1..59");
    end

    typedef enum logic [2:0] {
        ST_CLOCK,
        ST_ADJ_CH,
        ST_ADJ_CM,
        ST_ADJ_AH,
        ST_ADJ_AM,
        ST_RING
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_C,
        ACT_R,
        ACT_L,
        ACT_U,
        ACT_D
    } act_t;

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       alm_hour_q, alm_hour_d;
    logic [5:0]       alm_min_q, alm_min_d;

    act_t             act;
    logic [SEC_W-1:0] sec_adv;
    logic [4:0]       hour_adv;
    logic [5:0]       min_adv;
    logic             rollover;
    logic             alarm_hit;
    logic             fire;

    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hour_dec(input logic [4:0] h);
        return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] min_inc(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

    function automatic logic [5:0] min_dec(input logic [5:0] m);
        return (m == 6'd0) ? 6'd59 : m - 6'd1;
    endfunction

    // Only the highest-priority button of a cycle is acted on.
    always_comb begin
        act = ACT_NONE;
        if (btn_c)      act = ACT_C;
        else if (btn_r) act = ACT_R;
        else if (btn_l) act = ACT_L;
        else if (btn_u) act = ACT_U;
        else if (btn_d) act = ACT_D;
    end

    // Time the clock would hold after this cycle if it is running.
    always_comb begin
        sec_adv  = sec_q;
        min_adv  = min_q;
        hour_adv = hour_q;
        rollover = 1'b0;
        if (tick_1hz) begin
            if (sec_q == SEC_LAST) begin
                sec_adv  = '0;
                rollover = 1'b1;
                min_adv  = min_inc(min_q);
                if (min_q == 6'd59) hour_adv = hour_inc(hour_q);
            end else begin
                sec_adv = sec_q + SEC_W'(1);
            end
        end
    end

    // Alarm only fires on a tick-driven rollover, never on a static match.
    assign alarm_hit = rollover && (hour_adv == alm_hour_q) && (min_adv == alm_min_q);

`ifdef CLOCK_SNOOZE_EN
    logic       snz_armed_q, snz_armed_d;
    logic [4:0] snz_hour_q, snz_hour_d;
    logic [5:0] snz_min_q, snz_min_d;
    logic [6:0] snz_sum;
    logic [4:0] snz_tgt_hour;
    logic [5:0] snz_tgt_min;

    // Snooze target = current hour:min + SNOOZE_MIN, wrapping the day.
    always_comb begin
        snz_sum      = {1'b0, min_q} + 7'(SNOOZE_MIN);
        snz_tgt_hour = hour_q;
        snz_tgt_min  = snz_sum[5:0];
        if (snz_sum >= 7'd60) begin
            snz_tgt_min  = 6'(snz_sum - 7'd60);
            snz_tgt_hour = hour_inc(hour_q);
        end
    end

    assign fire = alarm_hit ||
                  (snz_armed_q && rollover && (hour_adv == snz_hour_q) && (min_adv == snz_min_q));
`else
    assign fire = alarm_hit;
`endif

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        hour_d     = hour_q;
        min_d      = min_q;
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;
`ifdef CLOCK_SNOOZE_EN
        snz_armed_d = snz_armed_q;
        snz_hour_d  = snz_hour_q;
        snz_min_d   = snz_min_q;
`endif
        case (state_q)
            ST_CLOCK: begin
                sec_d  = sec_adv;
                min_d  = min_adv;
                hour_d = hour_adv;
                // A tick arriving with btn_c still counts; its match is dropped.
                if (act == ACT_C) begin
                    state_d = ST_ADJ_CH;
`ifdef CLOCK_SNOOZE_EN
                    snz_armed_d = 1'b0;
`endif
                end else if (fire) begin
                    state_d = ST_RING;
`ifdef CLOCK_SNOOZE_EN
                    snz_armed_d = 1'b0;
`endif
                end
            end
            ST_RING: begin
                sec_d  = sec_adv;
                min_d  = min_adv;
                hour_d = hour_adv;
`ifdef CLOCK_SNOOZE_EN
                if (act == ACT_C) begin
                    state_d     = ST_CLOCK;
                    snz_armed_d = 1'b0;
                end else if (act == ACT_U) begin
                    state_d     = ST_CLOCK;
                    snz_armed_d = 1'b1;
                    snz_hour_d  = snz_tgt_hour;
                    snz_min_d   = snz_tgt_min;
                end
`else
                if (act != ACT_NONE) state_d = ST_CLOCK;
`endif
            end
            default: begin
`ifdef CLOCK_SNOOZE_EN
                snz_armed_d = 1'b0;
`endif
                case (act)
                    ACT_C: begin
                        state_d = ST_CLOCK;
                        sec_d   = '0;
                    end
                    ACT_R: begin
                        case (state_q)
                            ST_ADJ_CH: state_d = ST_ADJ_CM;
                            ST_ADJ_CM: state_d = ST_ADJ_AH;
                            ST_ADJ_AH: state_d = ST_ADJ_AM;
                            default:   state_d = ST_ADJ_CH;
                        endcase
                    end
                    ACT_L: begin
                        case (state_q)
                            ST_ADJ_CH: state_d = ST_ADJ_AM;
                            ST_ADJ_CM: state_d = ST_ADJ_CH;
                            ST_ADJ_AH: state_d = ST_ADJ_CM;
                            default:   state_d = ST_ADJ_AH;
                        endcase
                    end
                    ACT_U, ACT_D: begin
                        case (state_q)
                            ST_ADJ_CH: hour_d     = (act == ACT_U) ? hour_inc(hour_q) : hour_dec(hour_q);
                            ST_ADJ_CM: min_d      = (act == ACT_U) ? min_inc(min_q) : min_dec(min_q);
                            ST_ADJ_AH: alm_hour_d = (act == ACT_U) ? hour_inc(alm_hour_q) : hour_dec(alm_hour_q);
                            default:   alm_min_d  = (act == ACT_U) ? min_inc(alm_min_q) : min_dec(alm_min_q);
                        endcase
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLOCK;
            sec_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            alm_hour_q <= '0;
            alm_min_q  <= '0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            alm_hour_q <= alm_hour_d;
            alm_min_q  <= alm_min_d;
        end
    end

`ifdef CLOCK_SNOOZE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snz_armed_q <= 1'b0;
            snz_hour_q  <= '0;
            snz_min_q   <= '0;
        end else begin
            snz_armed_q <= snz_armed_d;
            snz_hour_q  <= snz_hour_d;
            snz_min_q   <= snz_min_d;
        end
    end
`endif

    // Moore outputs, decoded from registered state only.
    always_comb begin
        disp_hour    = hour_q;
        disp_min     = min_q;
        dp_blink_en  = 1'b0;
        adj_led      = 4'b0000;
        adj_mode_led = 1'b1;
        buzzer       = 1'b0;
        case (state_q)
            ST_CLOCK: begin
                dp_blink_en  = 1'b1;
                adj_mode_led = 1'b0;
            end
            ST_RING: begin
                dp_blink_en  = 1'b1;
                adj_mode_led = 1'b0;
                buzzer       = 1'b1;
            end
            ST_ADJ_CH: adj_led = 4'b0001;
            ST_ADJ_CM: adj_led = 4'b0010;
            ST_ADJ_AH: begin
                adj_led   = 4'b0100;
                disp_hour = alm_hour_q;
                disp_min  = alm_min_q;
            end
            default: begin
                adj_led   = 4'b1000;
                disp_hour = alm_hour_q;
                disp_min  = alm_min_q;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_mode_controller.sv
// tb/tb_clock_mode_controller.sv - directed self-checking bench for clock_mode_controller

module tb_clock_mode_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic [4:0] disp_hour;
    logic [5:0] disp_min;
    logic       dp_blink_en;
    logic [3:0] adj_led;
    logic       adj_mode_led;
    logic       buzzer;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    clock_mode_controller #(.SEC_PER_MIN(4), .SNOOZE_MIN(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .btn_c        (btn_c),
        .btn_l        (btn_l),
        .btn_r        (btn_r),
        .btn_u        (btn_u),
        .btn_d        (btn_d),
        .disp_hour    (disp_hour),
        .disp_min     (disp_min),
        .dp_blink_en  (dp_blink_en),
        .adj_led      (adj_led),
        .adj_mode_led (adj_mode_led),
        .buzzer       (buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic drive(input logic [4:0] b, input logic t);
        @(negedge clk);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
        tick_1hz = t;
        @(negedge clk);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = 5'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic press(input logic [4:0] b);
        drive(b, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(5'b0, 1'b1);
    endtask

    task automatic check_time(input string tag, input int h, input int m);
        check({tag, ".hour"}, disp_hour, h);
        check({tag, ".min"}, disp_min, m);
    endtask

    initial begin
        // Reset held low while ticks and a button arrive: nothing moves.
        for (int i = 0; i < 10; i++) begin
            drive(5'b0, 1'b1);
            check_time("rst_tick", 0, 0);
        end
        press(B_C);
        check("rst.dp", dp_blink_en, 1);
        check("rst.adj_led", adj_led, 0);
        check("rst.adj_mode", adj_mode_led, 0);
        check("rst.buzzer", buzzer, 0);

        // Release; alarm 00:00 must not fire without a rollover onto it.
        @(negedge clk);
        rst = 1'b1;
        ticks(2);
        check_time("release", 0, 0);
        check("release.buzzer", buzzer, 0);

        // Hour +25 wraps to 1, minute -1 wraps to 59, exit clears seconds.
        press(B_C);
        check("adj.led_ch", adj_led, 4'b0001);
        check("adj.mode", adj_mode_led, 1);
        check("adj.dp", dp_blink_en, 0);
        repeat (25) press(B_U);
        check("adj.hour25", disp_hour, 1);
        check("adj.led_ch2", adj_led, 4'b0001);
        press(B_R);
        press(B_D);
        check("adj.min59", disp_min, 59);
        check("adj.led_cm", adj_led, 4'b0010);
        press(B_C);
        check("exit.mode", adj_mode_led, 0);
        check("exit.led", adj_led, 0);
        check("exit.dp", dp_blink_en, 1);
        ticks(3);
        check_time("sec_clr3", 1, 59);
        ticks(1);
        check_time("sec_clr4", 2, 0);

        // C beats R in the same cycle.
        press(B_C);
        press(B_R);
        check("prio.cm", adj_led, 4'b0010);
        press(B_C | B_R);
        check("prio.cr_led", adj_led, 0);
        check("prio.cr_mode", adj_mode_led, 0);

        // Set 23:59 (U beats D), then roll into 00:00 which matches alarm 00:00.
        press(B_C);
        check_time("set.enter", 2, 0);
        press(B_U | B_D);
        check("prio.ud", disp_hour, 3);
        repeat (4) press(B_D);
        check("set.hour23", disp_hour, 23);
        press(B_R);
        press(B_D);
        check_time("set.2359", 23, 59);
        press(B_C);
        ticks(3);
        check_time("wrap.pre", 23, 59);
        check("wrap.pre_buz", buzzer, 0);
        ticks(1);
        check_time("wrap.post", 0, 0);
        check("ring0.buzzer", buzzer, 1);

        // Asynchronous reset in the middle of a cycle during RING.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_ring.buzzer", buzzer, 0);
        check("rst_ring.dp", dp_blink_en, 1);
        check_time("rst_ring", 0, 0);
        @(negedge clk);
        rst = 1'b1;

        // Set alarm 00:02 and walk the field ring in both directions.
        press(B_C);
        press(B_R);
        press(B_R);
        check("alm.led_ah", adj_led, 4'b0100);
        press(B_R);
        check("alm.led_am", adj_led, 4'b1000);
        press(B_U);
        press(B_U);
        check_time("alm.disp", 0, 2);
        press(B_R);
        check("nav.r_wrap", adj_led, 4'b0001);
        check_time("nav.clock_disp", 0, 0);
        press(B_R | B_L);
        check("nav.rl", adj_led, 4'b0010);
        press(B_L);
        check("nav.l", adj_led, 4'b0001);
        press(B_L);
        check("nav.l_wrap", adj_led, 4'b1000);
        check("nav.alm_min", disp_min, 2);
        press(B_C);
        ticks(4);
        check_time("run.0001", 0, 1);
        check("run.no_ring", buzzer, 0);
        ticks(4);
        check_time("run.0002", 0, 2);
        check("ring2.buzzer", buzzer, 1);
        check("ring2.mode", adj_mode_led, 0);

`ifdef CLOCK_SNOOZE_EN
        press(B_D);
        check("snz.d_ignored", buzzer, 1);
        press(B_U);
        check("snz.off", buzzer, 0);
        ticks(19);
        check_time("snz.pre", 0, 6);
        check("snz.pre_buz", buzzer, 0);
        ticks(1);
        check("snz.refire", buzzer, 1);
        check_time("snz.fire_t", 0, 7);
        press(B_C);
        check("snz.cancel", buzzer, 0);
        ticks(20);
        check_time("snz.after", 0, 12);
        check("snz.no_refire", buzzer, 0);
`else
        press(B_D);
        check("ring.d_exit", buzzer, 0);
        check("ring.d_dp", dp_blink_en, 1);
        check_time("ring.d_time", 0, 2);
        // Tick with btn_c in CLOCK still counts while entering adjust.
        ticks(3);
        drive(B_C, 1'b1);
        check("tick_c.led", adj_led, 4'b0001);
        check_time("tick_c.time", 0, 3);
        press(B_C);
        check("tick_c.exit", adj_mode_led, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_mode_controller.md
CLOCK_MODE_CONTROLLER -- requirements
Module: clock_mode_controller

Interface
REQ-001 Parameter SEC_PER_MIN, default 60, ticks per minute (reduced in simulation only).
REQ-002 Parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tick_1hz  input  1  one-cycle enable pulse, once per second.
REQ-006 btn_c, btn_l, btn_r, btn_u, btn_d  input  1 each  debounced one-cycle button pulses.
REQ-007 disp_hour  output  5  hour shown (0..23).
REQ-008 disp_min  output  6  minute shown (0..59).
REQ-009 dp_blink_en  output  1  decimal point blinking permitted.
REQ-010 adj_led  output  4  one-hot field being adjusted: [0] clock hour, [1] clock minute, [2] alarm hour, [3] alarm minute.
REQ-011 adj_mode_led  output  1  high in any adjust state.
REQ-012 buzzer  output  1  alarm sounding.

Function
REQ-013 Registered state; states: CLOCK, ADJ_CH, ADJ_CM, ADJ_AH, ADJ_AM, RING.
REQ-014 Internal registers: sec (0..SEC_PER_MIN-1), hour (0..23), min (0..59), alm_hour (0..23), alm_min (0..59).
REQ-015 In CLOCK and RING, each tick_1hz increments sec; at SEC_PER_MIN-1 sec wraps to 0 and min increments; min 59 wraps to 0 and hour increments; hour 23 wraps to 0.
REQ-016 In adjust states tick_1hz is ignored; sec, hour, min hold except through explicit edits.
REQ-017 Button priority when several pulse in one cycle: C > R > L > U > D; only the highest is acted on.
REQ-018 CLOCK: btn_c -> ADJ_CH next cycle; other buttons ignored.
REQ-019 Adjust states: btn_c -> CLOCK and sec cleared to 0; btn_r advances ADJ_CH->ADJ_CM->ADJ_AH->ADJ_AM->ADJ_CH; btn_l moves in reverse order.
REQ-020 Adjust states: btn_u increments, btn_d decrements the selected field with modular wrap (hour 23<->0, minute 59<->0); the update is visible on outputs the next cycle.
REQ-021 Alarm match: in CLOCK, when a tick causes the minute rollover and the new hour:min equals alm_hour:alm_min -> RING on that cycle's edge.
REQ-022 A tick coincident with btn_c in CLOCK is still counted; the state moves to ADJ_CH; a match on that tick is discarded.
REQ-023 RING: buzzer=1; time keeps counting; exit behaviour per REQ-031/REQ-032.
REQ-024 disp_hour/disp_min show alm_hour/alm_min in ADJ_AH, ADJ_AM, else hour/min.
REQ-025 dp_blink_en=1 in CLOCK and RING, 0 otherwise; adj_mode_led=1 in adjust states only; adj_led all zero outside adjust states.
REQ-026 All outputs are Moore, decoded from registered state and counters; no combinational path from inputs to outputs.

Reset
REQ-027 On rst low, immediately and asynchronously: state=CLOCK, sec=0, hour=0, min=0, alm_hour=0, alm_min=0, snooze registers cleared.
REQ-028 Reset outputs: disp_hour=0, disp_min=0, dp_blink_en=1, adj_led=0000, adj_mode_led=0, buzzer=0.
REQ-029 Reset asserted mid-RING or mid-edit aborts it; no pending edit or alarm survives.
REQ-030 Alarm at 00:00 does not fire at reset release; match occurs only on a tick-driven rollover.

Configuration
REQ-031 Macro CLOCK_SNOOZE_EN defined: in RING, btn_u -> CLOCK, buzzer off, snooze target = current hour:min + SNOOZE_MIN (mod 24h) armed; the alarm re-fires on a rollover to that target; btn_c -> CLOCK and cancels any armed snooze; other buttons are ignored; entering any adjust state cancels snooze.
REQ-032 Macro not defined: any button pulse in RING -> CLOCK, buzzer off; no snooze logic present.

Verification
REQ-033 Reset low, 10 ticks -> all outputs at REQ-028 values, disp 00:00 throughout.
REQ-034 SEC_PER_MIN=4, time 23:59 sec 3, one tick -> disp 00:00, sec 0.
REQ-035 btn_c; btn_u x25 -> disp_hour 1, adj_led 0001; btn_r, btn_d -> disp_min 59, adj_led 0010; btn_c -> CLOCK, sec 0.
REQ-036 Alarm 00:02, time 00:01 sec SEC_PER_MIN-1, tick -> RING, buzzer 1 next cycle; btn_d (macro off) -> buzzer 0, CLOCK.
REQ-037 Macro on, SNOOZE_MIN=5, ring at 06:30, btn_u -> buzzer 0; rollover to 06:35 -> buzzer 1; btn_c -> buzzer 0, no refire at 06:40.
REQ-038 btn_c and btn_r same cycle in ADJ_CM -> CLOCK (C wins); rst low during RING -> buzzer 0 immediately.
